vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Round-robin arbiter that shares the single VGA adapter write port (x, y, colour, plot) among several drawing clients: obstacle, player sprite, score renderer. Each client requests the port, receives an exclusive grant, and streams pixels for one object, such as a 4x4 square. The arbiter forwards the granted client's pixels through one register stage to the adapter. It enforces a per-grant pixel budget so that no client starves the others.

## Interface
Parameters:
- NUM_REQ, default 3: number of clients.
- X_W, default 8: x coordinate width.
- Y_W, default 7: y coordinate width.
- C_W, default 3: colour width.
- MAX_BURST, default 16: maximum pixels accepted per grant.
- TIMEOUT, default 64: idle-owner cycles before forced release; used only with the macro below.

Ports (reset resetn, asynchronous, active-low; clock clock):
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-client request; held high for the whole transfer.
- gnt  out  NUM_REQ  one-hot grant, registered.
- px_valid  in  NUM_REQ  per-client pixel strobe; honoured only for the granted client.
- px_last  in  NUM_REQ  marks the client's final pixel of its object.
- px_x  in  NUM_REQ*X_W  packed x coordinates, client i at bits [i*X_W +: X_W].
- px_y  in  NUM_REQ*Y_W  packed y coordinates.
- px_colour  in  NUM_REQ*C_W  packed colours.
- vga_x  out  X_W  registered x to the adapter.
- vga_y  out  Y_W  registered y to the adapter.
- vga_colour  out  C_W  registered colour to the adapter.
- vga_plot  out  1  registered write strobe to the adapter.
- busy  out  1  high while any grant is held.

## Operation
State machine:
- IDLE: if any req bit is high, pick the winner round-robin, starting at rr_ptr+1 and wrapping modulo NUM_REQ. Load gnt with the winner, set rr_ptr to the winner, clear burst_cnt, go to OWN. With no requests, stay in IDLE.
- OWN: each cycle with px_valid[owner] high, the pixel is accepted and burst_cnt increments; it is 5 bits wide for MAX_BURST=16. Leave OWN and go to IDLE, clearing gnt, on the first of these events:
  - an accepted px_last;
  - burst_cnt reaching MAX_BURST on an accepted pixel;
  - req[owner] falling.
- Pixels from non-granted clients are ignored; they raise no error and have no effect.
- A client that still requests after release competes again in IDLE. It is lowest priority there because rr_ptr points at it.

Reset values:
- gnt=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- rr_ptr=NUM_REQ-1, so client 0 wins first. State=IDLE, burst_cnt=0.

Boundary cases:
- Simultaneous px_last and budget exhaustion: a single release.
- req drop in the same cycle as px_valid: that pixel is still forwarded, then release.
- Reset asserted mid-burst: immediately clears gnt and vga_plot; the pixel in flight is lost.

## Timing
- Grant latency: req sampled high in IDLE gives gnt high on the next edge. Minimum 1 cycle; maximum (NUM_REQ-1)*(MAX_BURST+2)+1 under full contention.
- Pixel latency: an accepted px_valid gives vga_plot, vga_x, vga_y and vga_colour valid exactly 1 cycle later. vga_plot is high for one cycle per pixel.
- Release: gnt drops on the edge following the terminating event. IDLE then occupies at least one cycle, so back-to-back grants are separated by at least 1 cycle with gnt=0.
- busy equals OWN state, registered.

## Configuration
- VGA_ARB_TIMEOUT_EN defined: a counter runs in OWN and is cleared on each accepted pixel. After TIMEOUT consecutive cycles without px_valid[owner], the arbiter force-releases to IDLE, as if px_last had been accepted.
- VGA_ARB_TIMEOUT_EN undefined: there is no counter, and an owner may hold the grant indefinitely while keeping req high.

## Structure
- Shared package vga_arb_pkg holds:
  - state encoding localparams: IDLE=1'b0, OWN=1'b1;
  - default widths X_W, Y_W, C_W;
  - MAX_BURST and TIMEOUT defaults.
- One sub-module, rr_pick: a combinational round-robin selector. Inputs are req and rr_ptr; outputs are a one-hot winner, a winner index and an any-request flag. The top-level holds the FSM, counters and output registers.

## Test plan
- Single client 1 streams 16 pixels with px_last on the 16th: gnt=3'b010 one cycle after req, then 16 vga_plot pulses each 1 cycle after px_valid with matching x/y/colour, then gnt=0.
- All three req high from reset: grant order is 0, 1, 2, 0, with a gnt=0 gap of at least 1 cycle between each grant.
- Client 0 streams 20 pixels with no px_last: exactly 16 forwarded, then release. It regains the grant only after clients 1 and 2 are served, if they request.
- Non-owner client 2 pulses px_valid while client 0 owns the grant: no vga_plot carries client 2's coordinates.
- resetn pulled low mid-burst after 5 pixels: gnt, vga_plot and busy are 0 in the same cycle; after release, client 0 wins first.
- With VGA_ARB_TIMEOUT_EN: the owner holds req with no px_valid for 64 cycles, giving release on cycle 65. Without the macro, the grant is still held at cycle 200.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared types, default widths and helpers for the VGA plot arbiter.
package vga_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DEF_X_W       = 8;
    localparam int DEF_Y_W       = 7;
    localparam int DEF_C_W       = 3;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_TIMEOUT   = 64;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin selector: the client after rr_ptr has highest
// priority and rr_ptr itself has lowest.
module rr_pick
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = cnt_width(NUM_REQ - 1)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any_req
);

    int cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_req    = |req;
        cand       = 0;
        // Scan from the farthest offset down so the nearest requester overwrites last.
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(rr_ptr) + off) % NUM_REQ;
            if (req[cand]) begin
                win_onehot       = '0;
                win_onehot[cand] = 1'b1;
                win_idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter write port with a per-grant pixel budget.
// Optional owner-idle forced release is enabled by defining VGA_ARB_TIMEOUT_EN.
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int C_W       = DEF_C_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic [NUM_REQ-1:0]     px_valid,
    input  logic [NUM_REQ-1:0]     px_last,
    input  logic [NUM_REQ*X_W-1:0] px_x,
    input  logic [NUM_REQ*Y_W-1:0] px_y,
    input  logic [NUM_REQ*C_W-1:0] px_colour,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic                   busy
);

    localparam int IDX_W   = cnt_width(NUM_REQ - 1);
    localparam int BURST_W = cnt_width(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("vga_plot_arbiter: MAX_BURST and TIMEOUT must be at least 1");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [X_W-1:0]     vga_x_q, vga_x_d;
    logic [Y_W-1:0]     vga_y_q, vga_y_d;
    logic [C_W-1:0]     vga_colour_q, vga_colour_d;
    logic               vga_plot_q, vga_plot_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_req    (any_req)
    );

    logic owning, accept, done_last, done_budget, owner_gone, timed_out, drop_grant;

    assign owning      = (state_q == OWN);
    assign accept      = owning && px_valid[owner_q];
    assign done_last   = accept && px_last[owner_q];
    assign done_budget = accept && (burst_cnt_q == BURST_LAST);
    assign owner_gone  = owning && !req[owner_q];
    assign drop_grant  = done_last || done_budget || owner_gone || timed_out;

`ifdef VGA_ARB_TIMEOUT_EN
    localparam int IDLE_W = cnt_width(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Counts consecutive owner cycles without a pixel; any accepted pixel restarts it.
    assign timed_out = owning && !accept && (idle_cnt_q == IDLE_LAST);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!owning || accept) idle_cnt_d = '0;
        else                   idle_cnt_d = idle_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) idle_cnt_q <= '0;
        else         idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    // NOTE: every _d starts from its _q (or a fixed value) so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = OWN;
                    gnt_d       = win_onehot;
                    owner_d     = win_idx;
                    rr_ptr_d    = win_idx;
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                // The terminating pixel is still forwarded in the same cycle as release.
                if (accept) begin
                    vga_plot_d   = 1'b1;
                    vga_x_d      = px_x[int'(owner_q)*X_W +: X_W];
                    vga_y_d      = px_y[int'(owner_q)*Y_W +: Y_W];
                    vga_colour_d = px_colour[int'(owner_q)*C_W +: C_W];
                    burst_cnt_d  = burst_cnt_q + 1'b1;
                end
                if (drop_grant) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign gnt        = gnt_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = (state_q == OWN);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: grant order, pixel forwarding, budget,
// non-owner isolation, async reset and owner hold / timeout release.
module tb_vga_plot_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  req, gnt, px_valid, px_last;
    logic [23:0] px_x;
    logic [20:0] px_y;
    logic [8:0]  px_colour;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy;

    int n_tests = 0;
    int n_fail  = 0;

    vga_plot_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .gnt        (gnt),
        .px_valid   (px_valid),
        .px_last    (px_last),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_colour  (px_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_px(input int i, input logic v, input logic l,
                            input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        px_valid[i]         = v;
        px_last[i]          = l;
        px_x[i*8 +: 8]      = x;
        px_y[i*7 +: 7]      = y;
        px_colour[i*3 +: 3] = c;
    endtask

    function automatic logic [31:0] pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        return {14'd0, x, y, c};
    endfunction

    function automatic logic [31:0] vga_pix();
        return {14'd0, vga_x, vga_y, vga_colour};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; req = '0; px_valid = '0; px_last = '0;
        px_x = '0; px_y = '0; px_colour = '0;
        #12;
        check("reset_gnt", gnt, 3'b000);
        check("reset_plot", vga_plot, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_pix", vga_pix(), 32'd0);
        resetn = 1'b1;
        tick();

        // Client 1 alone: 16 pixels, px_last on the 16th coinciding with the budget.
        req = 3'b010;
        tick();
        check("t1_gnt", gnt, 3'b010);
        check("t1_busy", busy, 1'b1);
        for (int k = 0; k < 16; k++) begin
            drive_px(1, 1'b1, k == 15, 8'(10 + k), 7'(20 + k), 3'(k));
            tick();
            check("t1_plot", vga_plot, 1'b1);
            check("t1_pix", vga_pix(), pix(8'(10 + k), 7'(20 + k), 3'(k)));
            check("t1_gnt_hold", gnt, (k == 15) ? 3'b000 : 3'b010);
        end
        drive_px(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        req = 3'b000;
        tick();
        check("t1_plot_end", vga_plot, 1'b0);
        check("t1_busy_end", busy, 1'b0);

        // All three request from reset: order 0,1,2,0 with idle gaps.
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 3; i++) drive_px(i, 1'b1, 1'b1, 8'(8'h40 + i), 7'(7'h10 + i), 3'(i + 1));
        tick(); check("t2_g0", gnt, 3'b001);
        tick(); check("t2_gap0", gnt, 3'b000);
        check("t2_pix0", vga_pix(), pix(8'h40, 7'h10, 3'd1));
        tick(); check("t2_g1", gnt, 3'b010);
        check("t2_noplot", vga_plot, 1'b0);
        tick(); check("t2_gap1", gnt, 3'b000);
        check("t2_pix1", vga_pix(), pix(8'h41, 7'h11, 3'd2));
        tick(); check("t2_g2", gnt, 3'b100);
        tick(); check("t2_gap2", gnt, 3'b000);
        check("t2_pix2", vga_pix(), pix(8'h42, 7'h12, 3'd3));
        tick(); check("t2_g0_again", gnt, 3'b001);
        req = 3'b000; px_valid = '0; px_last = '0;
        tick(); check("t2_reqdrop", gnt, 3'b000);
        check("t2_reqdrop_plot", vga_plot, 1'b0);

        // Client 0 streams 20 pixels without px_last: only 16 forwarded.
        req = 3'b001;
        tick(); check("t3_gnt", gnt, 3'b001);
        req = 3'b111;
        for (int k = 0; k < 20; k++) begin
            drive_px(0, 1'b1, 1'b0, 8'(k + 1), 7'(k + 2), 3'(k));
            tick();
            if (k < 16) begin
                check("t3_plot", vga_plot, 1'b1);
                check("t3_pix", vga_pix(), pix(8'(k + 1), 7'(k + 2), 3'(k)));
                check("t3_gnt", gnt, (k == 15) ? 3'b000 : 3'b001);
            end else begin
                check("t3_no_extra", vga_plot, 1'b0);
                check("t3_gnt_c1", gnt, 3'b010);
            end
        end
        drive_px(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        drive_px(1, 1'b1, 1'b1, 8'h51, 7'h22, 3'd5);
        tick();
        check("t3_c1_pix", vga_pix(), pix(8'h51, 7'h22, 3'd5));
        check("t3_c1_rel", gnt, 3'b000);
        drive_px(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        req[1] = 1'b0;
        tick(); check("t3_c2_gnt", gnt, 3'b100);
        drive_px(2, 1'b1, 1'b1, 8'h62, 7'h33, 3'd6);
        tick();
        check("t3_c2_pix", vga_pix(), pix(8'h62, 7'h33, 3'd6));
        drive_px(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        req[2] = 1'b0;
        tick(); check("t3_c0_regain", gnt, 3'b001);

        // Non-owner client 2 strobes while client 0 owns.
        drive_px(2, 1'b1, 1'b0, 8'hEE, 7'h7E, 3'd7);
        tick();
        check("t4_ignored", vga_plot, 1'b0);
        check("t4_gnt", gnt, 3'b001);
        drive_px(0, 1'b1, 1'b0, 8'h33, 7'h11, 3'd1);
        tick();
        check("t4_owner_plot", vga_plot, 1'b1);
        check("t4_owner_pix", vga_pix(), pix(8'h33, 7'h11, 3'd1));
        drive_px(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);

        // Reset mid-burst after five pixels.
        for (int k = 0; k < 4; k++) begin
            drive_px(0, 1'b1, 1'b0, 8'(8'h70 + k), 7'(k), 3'(k));
            tick();
            check("t5_pix", vga_pix(), pix(8'(8'h70 + k), 7'(k), 3'(k)));
        end
        drive_px(0, 1'b1, 1'b0, 8'h7F, 7'h7F, 3'd7);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_gnt", gnt, 3'b000);
        check("t5_rst_plot", vga_plot, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_pix", vga_pix(), 32'd0);
        resetn = 1'b1;
        drive_px(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        req = 3'b111;
        tick(); check("t5_first_after_rst", gnt, 3'b001);
        req = 3'b000;
        tick(); check("t5_rel", gnt, 3'b000);

        // req drops in the same cycle as px_valid: pixel forwarded, then release.
        req = 3'b010;
        tick(); check("t6_gnt", gnt, 3'b010);
        drive_px(1, 1'b1, 1'b0, 8'h15, 7'h16, 3'd2);
        req = 3'b000;
        tick();
        check("t6_plot", vga_plot, 1'b1);
        check("t6_pix", vga_pix(), pix(8'h15, 7'h16, 3'd2));
        check("t6_rel", gnt, 3'b000);
        drive_px(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        tick(); check("t6_plot_end", vga_plot, 1'b0);

        // Owner holds req with no pixels.
        req = 3'b100;
        tick(); check("t7_gnt", gnt, 3'b100);
`ifdef VGA_ARB_TIMEOUT_EN
        repeat (63) tick();
        check("t7_hold_63", gnt, 3'b100);
        tick();
        check("t7_timeout_rel", gnt, 3'b000);
        check("t7_timeout_busy", busy, 1'b0);
`else
        repeat (199) tick();
        check("t7_hold_200", gnt, 3'b100);
        check("t7_busy_200", busy, 1'b1);
`endif
        req = 3'b000;
        tick();
        tick(); check("t7_final", gnt, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
